irq_latch_arbiter: RTL

//  Edge-triggered interrupt request latch bank with priority arbiter for System86 CPU IRQ lines.

---
 rtl/irq_latch_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/irq_latch_arbiter.sv
// rtl/irq_latch_arbiter.sv - edge-latched IRQ bank with priority arbiter driving one active-low nIRQ
// Optional rotating priority: define IRQ_ARB_ROUND_ROBIN_EN.
module irq_latch_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int VEC_WIDTH = 2
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic                 MASK_WE,
  input  logic [NUM_REQ-1:0]   MASK_IN,
  input  logic                 ACK,
  input  logic                 EOI,
  output logic                 nIRQ,
  output logic [VEC_WIDTH-1:0] VEC,
  output logic                 VEC_VALID,
  output logic [NUM_REQ-1:0]   PENDING,
  output logic                 BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SERVICE} state_t;

  state_t                 r_state;
  logic [NUM_REQ-1:0]     r_req_prev;
  logic [NUM_REQ-1:0]     r_pending;
  logic [NUM_REQ-1:0]     r_mask;
  logic                   r_nirq;
  logic [VEC_WIDTH-1:0]   r_vec;
  logic                   r_vec_valid;
  logic                   r_busy;

  logic [NUM_REQ-1:0]     w_rise;
  logic [NUM_REQ-1:0]     w_elig;
  logic                   w_any;
  logic                   w_do_ack;
  logic [VEC_WIDTH-1:0]   w_winner;
  logic [NUM_REQ-1:0]     w_clr;
  logic [NUM_REQ-1:0]     w_pending_next;

  assign w_rise   = REQ & ~r_req_prev;
  assign w_elig   = r_pending & r_mask;
  assign w_any    = |w_elig;
  assign w_do_ack = (r_state == ST_PEND) && ACK && w_any;

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [VEC_WIDTH-1:0] r_ptr;
  logic [VEC_WIDTH-1:0] w_ptr_next;

  function automatic logic [VEC_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                   input logic [VEC_WIDTH-1:0] start);
    int idx;
    rr_pick = '0;
    // Walk backwards so the last hit is the one closest to the start pointer.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (elig[idx]) rr_pick = VEC_WIDTH'(idx);
    end
  endfunction

  always_comb begin
    w_winner   = rr_pick(w_elig, r_ptr);
    w_ptr_next = (int'(w_winner) + 1 >= NUM_REQ) ? '0 : w_winner + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nRESET)       r_ptr <= '0;
    else if (w_do_ack) r_ptr <= w_ptr_next;
  end
`else
  always_comb begin
    w_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_winner = VEC_WIDTH'(i);
    end
  end
`endif

  // A fresh edge on the bit being acknowledged must survive the clear.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_clr[i] = w_do_ack && (w_winner == VEC_WIDTH'(i));
    end
    w_pending_next = (r_pending & ~w_clr) | w_rise;
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_state     <= ST_IDLE;
      r_req_prev  <= '0;
      r_pending   <= '0;
      r_mask      <= '1;
      r_nirq      <= 1'b1;
      r_vec       <= '0;
      r_vec_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_req_prev <= REQ;
      r_pending  <= w_pending_next;
      if (MASK_WE) r_mask <= MASK_IN;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_PEND;
            r_nirq  <= 1'b0;
          end
        end
        ST_PEND: begin
          if (!w_any) begin
            r_state <= ST_IDLE;
            r_nirq  <= 1'b1;
          end else if (ACK) begin
            r_state     <= ST_SERVICE;
            r_nirq      <= 1'b1;
            r_vec       <= w_winner;
            r_vec_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (EOI) begin
            r_state     <= ST_IDLE;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_nirq  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign nIRQ      = r_nirq;
  assign VEC       = r_vec;
  assign VEC_VALID = r_vec_valid;
  assign PENDING   = r_pending;
  assign BUSY      = r_busy;

endmodule
